// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the data-memory responder:
//   - FSM state encodings (DMEM_IDLE / DMEM_BUSY / DMEM_DONE)
//   - latched operation encodings (OP_RD / OP_WR)
//   - DEFAULT_LATENCY and the data word width
//   - sat_inc16: saturating increment used by the optional access counters
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } dmem_op_t;

    localparam int DEFAULT_LATENCY = 5;
    localparam int DATA_W          = 8;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x DATA_W storage with a synchronous write port, a synchronous
// registered read port and a synchronous clear of every word on RESET.
// Ports:
//   CLK    in   clock
//   RESET  in   synchronous active-high clear (all words and rdata to 0)
//   we     in   write enable, writes wdata to mem[waddr]
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable, loads rdata from mem[raddr]
//   raddr  in   read address
//   rdata  out  registered read data, holds between reads
// ---------------------------------------------------------------------------
module dmem_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory side of the CPU load/store handshake. A READ or WRITE request
// stalls the CPU with BUSYWAIT for LATENCY cycles (request cycle included);
// the access commits on the LATENCY-th rising edge, then BUSYWAIT is low
// for one DONE cycle in which new requests are ignored.
// Ports:
//   CLK        in   clock
//   RESET      in   synchronous active-high reset (FSM, READDATA, memory)
//   READ       in   read request, level, held until BUSYWAIT falls
//   WRITE      in   write request, level; wins over READ when both are high
//   ADDRESS    in   word address, sampled once when the request is accepted
//   WRITEDATA  in   store data, sampled together with ADDRESS
//   READDATA   out  registered load data, changes only on a read commit
//   BUSYWAIT   out  stall to the CPU
// Optional (macro DMEM_ACCESS_CNT_EN):
//   RD_COUNT   out  saturating count of committed reads
//   WR_COUNT   out  saturating count of committed writes
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 1 << ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITEDATA,
    output logic [DATA_W-1:0] READDATA,
    output logic              BUSYWAIT
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0]       RD_COUNT,
    output logic [15:0]       WR_COUNT
`endif
);

    dmem_state_t       state, state_nx;
    logic [3:0]        cnt;
    dmem_op_t          op_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              req;
    logic              commit;
    logic              rd_commit;
    logic              wr_commit;

    assign req       = READ | WRITE;
    assign rd_commit = commit && (op_p0 == OP_RD);
    assign wr_commit = commit && (op_p0 == OP_WR);

    // Control state: FSM register and latency counter. The first BUSY cycle
    // already follows one stalled request cycle, so loading LATENCY-2 and
    // committing on the edge that sees zero gives LATENCY stalled cycles.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= DMEM_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                DMEM_IDLE: if (req) cnt <= 4'(LATENCY - 2);
                DMEM_BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                default:   ;
            endcase
        end
    end

    // Operand latches (stage p0): captured once on acceptance, so the CPU
    // may move ADDRESS/WRITEDATA while stalled without affecting the access.
    always_ff @(posedge CLK) begin
        if ((state == DMEM_IDLE) && req) begin
            op_p0    <= WRITE ? OP_WR : OP_RD;
            addr_p0  <= ADDRESS;
            wdata_p0 <= WRITEDATA;
        end
    end

    always_comb begin
        state_nx = state;
        BUSYWAIT = 1'b0;
        commit   = 1'b0;
        case (state)
            DMEM_IDLE: begin
                // Combinational so the CPU stalls in the request cycle itself.
                BUSYWAIT = req;
                if (req) state_nx = DMEM_BUSY;
            end
            DMEM_BUSY: begin
                BUSYWAIT = 1'b1;
                if (cnt == 4'd0) begin
                    commit   = 1'b1;
                    state_nx = DMEM_DONE;
                end
            end
            DMEM_DONE: begin
                // The CPU drops its request on BUSYWAIT falling; ignore it here.
                state_nx = DMEM_IDLE;
            end
            default: state_nx = DMEM_IDLE;
        endcase
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .CLK   (CLK),
        .RESET (RESET),
        .we    (wr_commit),
        .waddr (addr_p0),
        .wdata (wdata_p0),
        .re    (rd_commit),
        .raddr (addr_p0),
        .rdata (READDATA)
    );

`ifdef DMEM_ACCESS_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            RD_COUNT <= '0;
            WR_COUNT <= '0;
        end else begin
            if (rd_commit) RD_COUNT <= sat_inc16(RD_COUNT);
            if (wr_commit) WR_COUNT <= sat_inc16(WR_COUNT);
        end
    end
`endif

endmodule
